// File: rtl/nes_pad_reader.sv
// NES controller poller: drives latch/pulse on a fixed poll interval, shifts in the
// eight active-low button bits and publishes held state plus one-cycle press strobes.
module nes_pad_reader #(
  parameter int HALF_PERIOD = 300,
  parameter int POLL_CYCLES = 833333,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_pulse,
  output logic [7:0] buttons,
  output logic       btn_valid,
  output logic [7:0] btn_pressed
);

  localparam int PH_W = $clog2(2 * HALF_PERIOD);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_PULSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e           state_q;
  logic [PH_W-1:0]  ph_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             latch_q;
  logic             pulse_q;
  logic [7:0]       buttons_q;
  logic             valid_q;
  logic [7:0]       pressed_q;
  logic             poll_tick_s;

  assign pad_latch   = latch_q;
  assign pad_pulse   = pulse_q;
  assign buttons     = buttons_q;
  assign btn_valid   = valid_q;
  assign btn_pressed = pressed_q;

  // Free-running poll counter next state; wraps after the last count.
  always_comb begin
    poll_tick_s = (cnt_q == CNT_LAST);
    if (poll_tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Poll counter and pad_data synchroniser (idle level is released/high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= pad_data;
      sync2_q <= sync1_q;
    end
  end

  // Read-frame sequencer with registered pad strobes and button outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      buttons_q <= 8'h00;
      valid_q   <= 1'b0;
      pressed_q <= 8'h00;
    end else begin
      valid_q   <= 1'b0;
      pressed_q <= 8'h00;
      case (state_q)
        ST_IDLE: begin
          latch_q <= 1'b0;
          pulse_q <= 1'b0;
          if (poll_tick_s) begin
            state_q   <= ST_LATCH;
            ph_q      <= '0;
            bit_idx_q <= 3'd0;
            latch_q   <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (ph_q == LATCH_LAST) begin
            state_q <= ST_LOW;
            ph_q    <= '0;
            latch_q <= 1'b0;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        ST_LOW: begin
          if (ph_q == HALF_LAST) begin
            // Sample at the end of the low phase, furthest from the pad's shift edge.
            shift_q[bit_idx_q] <= ~sync2_q;
            ph_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_PULSE;
              pulse_q <= 1'b1;
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        ST_PULSE: begin
          if (ph_q == HALF_LAST) begin
            state_q   <= ST_LOW;
            ph_q      <= '0;
            pulse_q   <= 1'b0;
            bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        ST_DONE: begin
          buttons_q <= shift_q;
          pressed_q <= shift_q & ~buttons_q;
          valid_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ph_q    <= '0;
          latch_q <= 1'b0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural NES pad model plus frame-level expectations
// derived from frame timing arithmetic and the held/pressed button rules.
module tb_nes_pad_reader;
  localparam int H = 4;
  localparam int P = 100;
  localparam int W = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_pulse;
  logic [7:0] buttons;
  logic       btn_valid;
  logic [7:0] btn_pressed;

  int checks = 0;
  int errors = 0;

  logic [7:0] pad_btn = 8'h00;
  logic       glitch = 1'b0;
  logic [3:0] idx = 4'd0;
  logic       pulse_prev = 1'b0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_prev = 8'h00;

  nes_pad_reader #(.HALF_PERIOD(H), .POLL_CYCLES(P), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data), .pad_latch(pad_latch),
    .pad_pulse(pad_pulse), .buttons(buttons), .btn_valid(btn_valid),
    .btn_pressed(btn_pressed)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, advance one bit per pulse rising edge.
  always @(posedge clk) begin
    pulse_prev <= pad_pulse;
    if (pad_latch) idx <= 4'd0;
    else if (pad_pulse && !pulse_prev && idx < 4'd8) idx <= idx + 4'd1;
  end
  assign pad_data = glitch ^ ((idx < 4'd8) ? ~pad_btn[idx[2:0]] : 1'b1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Always-on protocol checks: strobes never overlap, btn_valid is single-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("latch_pulse_overlap", 32'(pad_latch & pad_pulse), 32'd0);
      if (valid_prev) chk("valid_twice", 32'(btn_valid), 32'd0);
    end
    valid_prev <= btn_valid;
  end

  // Waits for the next btn_valid and compares against the pad's held buttons.
  task automatic wait_frame(input string tag);
    logic [7:0] exp_btn;
    int n;
    n = 0;
    while (!btn_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!btn_valid) begin
      chk({tag, "_timeout"}, 32'd1, 32'd0);
    end else begin
      exp_btn = pad_btn;
      chk({tag, "_buttons"}, 32'(buttons), 32'(exp_btn));
      chk({tag, "_pressed"}, 32'(btn_pressed), 32'(exp_btn & ~exp_prev));
      exp_prev = exp_btn;
      @(negedge clk);
      chk({tag, "_pressed_clr"}, 32'(btn_pressed), 32'd0);
      chk({tag, "_hold"}, 32'(buttons), 32'(exp_btn));
    end
  endtask

  initial begin
    int k;
    int vcnt;
    int r;
    int np;
    logic exp_l;
    logic exp_p;
    logic prev_lp;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_pulse", 32'(pad_pulse), 32'd0);
    chk("rst_buttons", 32'(buttons), 32'd0);
    chk("rst_valid", 32'(btn_valid), 32'd0);
    chk("rst_pressed", 32'(btn_pressed), 32'd0);

    // 1: first frame timing with pad idle-high
    rst_n = 1'b1;
    vcnt = 0;
    for (k = 1; k <= 175; k++) begin
      @(negedge clk);
      exp_l = (k >= P) && (k < P + 2 * H);
      r = k - (P + 2 * H);
      exp_p = (r >= 0) && (r < 14 * H) && ((r % (2 * H)) >= H);
      chk("t1_latch", 32'(pad_latch), 32'(exp_l));
      chk("t1_pulse", 32'(pad_pulse), 32'(exp_p));
      if (btn_valid) begin
        vcnt++;
        chk("t1_pressed", 32'(btn_pressed), 32'd0);
      end
    end
    chk("t1_valid_count", 32'(vcnt), 32'd1);
    chk("t1_buttons", 32'(buttons), 32'd0);

    // 2: A+Up held for two frames
    pad_btn = 8'h11;
    wait_frame("t2_f1");
    wait_frame("t2_f2");

    // 3: release A, press Right
    pad_btn = 8'h90;
    wait_frame("t3");

    // 5: reset during third pulse, then latch restarts after exactly P cycles
    np = 0;
    k = 0;
    while (np < 3 && k < 300) begin
      @(negedge clk);
      k++;
      if (pad_pulse && !pulse_prev) np++;
    end
    chk("t5_found_pulse3", 32'(np), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_pulse_async", 32'(pad_pulse), 32'd0);
    chk("t5_buttons_async", 32'(buttons), 32'd0);
    chk("t5_latch_async", 32'(pad_latch), 32'd0);
    chk("t5_valid_async", 32'(btn_valid), 32'd0);
    pad_btn = 8'h00;
    exp_prev = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!pad_latch && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("t5_latch_restart", 32'(k), 32'(P));
    wait_frame("t5_after");

    // 4: one-cycle glitches at the start of every LOW phase, no buttons pressed
    prev_lp = 1'b0;
    k = 0;
    while (!btn_valid && k < 300) begin
      @(negedge clk);
      k++;
      if (prev_lp && !(pad_latch || pad_pulse)) begin
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        k++;
      end
      prev_lp = pad_latch || pad_pulse;
    end
    chk("t4_seen_valid", 32'(btn_valid), 32'd1);
    chk("t4_buttons", 32'(buttons), 32'd0);
    chk("t4_pressed", 32'(btn_pressed), 32'd0);
    @(negedge clk);

    // 6: randomized button patterns, with occasional repeats to exercise holds
    for (int i = 0; i < 8; i++) begin
      if (i % 3 != 2) pad_btn = 8'($urandom_range(0, 255));
      wait_frame("t6_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
